// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master drives operands and out_ready; slave is the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
`ifdef PIPELINED_ADDER_SUB_EN
  logic             sub;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// STAGES-deep carry-segmented adder, WIDTH/STAGES bits per stage.
// Ports: clk, rst (sync, active-high), bus (pipelined_adder_if.slave:
// in_valid/in_ready/a/b/cin, out_valid/out_ready/sum/cout/ovf).
// Optional PIPELINED_ADDER_SUB_EN adds bus.sub (a - b - cin).
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_adder_if.slave  bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int L     = STAGES - 1;

  // Per-stage state; stage L is the output register.
  // r_a/r_b hold effective operands (b already inverted for sub),
  // r_s holds the chunks completed so far.
  logic             r_v [STAGES];
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_ovf;

  // Inputs seen by each stage, and what it produces.
  logic             w_v   [STAGES];
  logic [WIDTH-1:0] w_a   [STAGES];
  logic [WIDTH-1:0] w_b   [STAGES];
  logic [WIDTH-1:0] w_s   [STAGES];
  logic             w_c   [STAGES];
  logic [CHUNK:0]   w_add [STAGES];
  logic [WIDTH-1:0] w_sn  [STAGES];
  logic             w_ovf;
  logic             w_adv;

  assign w_adv = !r_v[L] || bus.out_ready;

  always_comb begin
    w_v[0] = bus.in_valid;
    w_a[0] = bus.a;
    w_s[0] = '0;
`ifdef PIPELINED_ADDER_SUB_EN
    w_b[0] = bus.sub ? ~bus.b : bus.b;
    w_c[0] = bus.sub ? ~bus.cin : bus.cin;
`else
    w_b[0] = bus.b;
    w_c[0] = bus.cin;
`endif
    for (int k = 1; k < STAGES; k++) begin
      w_v[k] = r_v[k-1];
      w_a[k] = r_a[k-1];
      w_b[k] = r_b[k-1];
      w_s[k] = r_s[k-1];
      w_c[k] = r_c[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_add[k] = {1'b0, w_a[k][k*CHUNK +: CHUNK]}
               + {1'b0, w_b[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, w_c[k]};
      w_sn[k]  = w_s[k];
      w_sn[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
    end
    // Same-sign operands with a sign flip in the result.
    w_ovf = (w_a[L][WIDTH-1] == w_b[L][WIDTH-1])
         && (w_sn[L][WIDTH-1] != w_a[L][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_v[k] <= 1'b0;
      r_s[L] <= '0;
      r_c[L] <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= w_v[k];
        // Output data only moves with a real beat so a
        // bubble leaves the last result on the bus.
        if (k != L || w_v[k]) begin
          r_a[k] <= w_a[k];
          r_b[k] <= w_b[k];
          r_s[k] <= w_sn[k];
          r_c[k] <= w_add[k][CHUNK];
        end
      end
      if (w_v[L]) r_ovf <= w_ovf;
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_v[L];
  assign bus.sum       = r_s[L];
  assign bus.cout      = r_c[L];
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4).
// Vector table plus streaming, backpressure and reset sequences.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(16)) bus ();

  pipelined_adder #(
    .WIDTH (16),
    .STAGES(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(
    logic [15:0] a, logic [15:0] b, logic cin, logic sub,
    logic [15:0] s, logic co, logic ov);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.s = s; v.co = co; v.ov = ov;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [15:0] a,
                       logic [15:0] b, logic cin, logic sub);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
`ifdef PIPELINED_ADDER_SUB_EN
    bus.sub      = sub;
`else
    if (sub) $display("note: sub ignored");
`endif
  endtask

  logic [15:0] exp_q[$];
  int          sent;
  int          got;
  int          stall_left;
  logic [16:0] t;

  initial begin
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;

    vec.push_back(mk(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0));
    vec.push_back(mk(16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0));
    vec.push_back(mk(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1));
    vec.push_back(mk(16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1));
    vec.push_back(mk(16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0));
    vec.push_back(mk(16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0, 0));
    vec.push_back(mk(16'h8000, 16'hFFFF, 0, 0, 16'h7FFF, 1, 1));
    vec.push_back(mk(16'h00FF, 16'h0001, 1, 0, 16'h0101, 0, 0));
`ifdef PIPELINED_ADDER_SUB_EN
    vec.push_back(mk(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0));
    vec.push_back(mk(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1));
`endif

    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_sum", 32'(bus.sum), 0);
    chk("rst_cout", 32'(bus.cout), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    tick();

    // Single-beat vectors with exact latency.
    foreach (vec[i]) begin
      drive(1'b1, vec[i].a, vec[i].b, vec[i].cin, vec[i].sub);
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      tick();
      chk($sformatf("vec%0d_early", i), 32'(bus.out_valid), 0);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("vec%0d_sum", i), 32'(bus.sum), 32'(vec[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vec[i].co));
      chk($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vec[i].ov));
      tick();
      chk($sformatf("vec%0d_once", i), 32'(bus.out_valid), 0);
    end

    // Streaming: 8 back-to-back beats.
    for (int c = 0; c < 12; c++) begin
      drive(c < 8, 16'(c), 16'(c << 8), 1'b0, 1'b0);
      #1;
      chk($sformatf("strm_rdy%0d", c), 32'(bus.in_ready), 1);
      tick();
      chk($sformatf("strm_val%0d", c), 32'(bus.out_valid),
          32'(c >= 3 && c <= 10));
      if (c >= 3 && c <= 10 && bus.out_valid)
        chk($sformatf("strm_sum%0d", c), 32'(bus.sum),
            32'(16'h0101 * (c - 3)));
      #1;
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();

    // Backpressure: 6 beats, 5-cycle stall after first result.
    sent = 0;
    got = 0;
    stall_left = -1;
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = (stall_left <= 0);
      if (sent < 6)
        drive(1'b1, 16'(16'h0010 * sent + 1), 16'h1111,
              1'b0, 1'b0);
      else
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      if (!bus.out_ready) begin
        chk("bp_stall_rdy", 32'(bus.in_ready), 0);
        chk("bp_stall_val", 32'(bus.out_valid), 1);
        if (exp_q.size() > 0)
          chk("bp_stall_sum", 32'(bus.sum), 32'(exp_q[0]));
        stall_left--;
      end else if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra", 32'(bus.out_valid), 0);
        end else begin
          chk($sformatf("bp_sum%0d", got), 32'(bus.sum),
              32'(exp_q.pop_front()));
          got++;
          if (stall_left < 0) stall_left = 5;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        t = {1'b0, bus.a} + {1'b0, bus.b};
        exp_q.push_back(t[15:0]);
        sent++;
      end
      tick();
    end
    bus.out_ready = 1'b1;
    chk("bp_sent", 32'(sent), 6);
    chk("bp_got", 32'(got), 6);

    // Reset mid-flight.
    drive(1'b1, 16'h0101, 16'h0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0202, 16'h0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0303, 16'h0001, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("mr_valid", 32'(bus.out_valid), 0);
    chk("mr_sum", 32'(bus.sum), 0);
    chk("mr_rdy", 32'(bus.in_ready), 1);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("mr_quiet%0d", c), 32'(bus.out_valid), 0);
    end
    drive(1'b1, 16'h0002, 16'h0003, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("mr_new_early", 32'(bus.out_valid), 0);
    tick();
    chk("mr_new_valid", 32'(bus.out_valid), 1);
    chk("mr_new_sum", 32'(bus.sum), 32'h0005);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised successor to the team's combinational ripple-carry adders.
- Splits a WIDTH-bit addition into STAGES registered carry-chain segments, so wide adds close timing at one result per cycle.
- Valid/ready handshake on both sides, carry-in, carry-out and signed-overflow flag.
- Sits between operand sources (register file, accumulators) and downstream datapath consumers.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline segments; CHUNK = WIDTH/STAGES bits are added per segment; STAGES >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts operand beat this cycle
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  result, a+b+cin mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: a[MSB]==b'[MSB] and sum[MSB]!=a[MSB]

Behaviour:
- Reset: already decided — one clock `clk`; reset `rst` is synchronous and active-high. Reset clears every stage valid bit, out_valid=0, sum=0, cout=0, ovf=0. in_ready is 1 in the cycle after reset release. Data registers other than outputs need not be cleared.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge.
- Pipeline advance: global enable adv = !out_valid || out_ready. in_ready = adv; it is combinational and does not depend on in_valid.
- Stall: when adv=0 every stage holds its contents and sum/cout/ovf stay stable. Outputs must not change while out_valid=1 and out_ready=0.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b plus the registered carry from stage k-1; stage 0 uses cin.
  - Registers the CHUNK-bit partial sum and the carry.
  - Chunks above k are carried forward in skew registers.
  - Completed lower chunks travel forward with the beat.
- Latency: exactly STAGES cycles from accept to out_valid=1, given continuous out_ready=1.
- Throughput: one beat per cycle, with no bubbles when in_valid=1 and out_ready=1 continuously.
- Bubbles: a stage whose valid bit is 0 carries no data. A bubble never produces out_valid. Bubbles collapse only by normal advance (no bubble squeezing required).
- Ordering: results appear strictly in acceptance order; no beat is dropped or duplicated.
- Arithmetic:
  - {cout,sum} = a + b + cin, computed in WIDTH+1 bits.
  - Wrap-around is natural: 0xFFFF+0x0001 -> sum=0x0000, cout=1.
  - ovf is computed from the MSB chunk in the final stage.
- Simultaneous events: on a full pipe with out_ready=1 and in_valid=1, the result retires and a new beat enters in the same cycle.
- Reset mid-operation: rst=1 discards all in-flight beats. No result from before reset may appear afterwards.
- STAGES=1 degenerates to a single registered adder with latency 1.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- Defined:
  - Extra port `sub` (input, 1 bit) is sampled with the operands.
  - Effective operand b' = sub ? ~b : b; effective carry c' = sub ? ~cin : cin.
  - sub=1 therefore yields a - b - cin. cout=1 means no borrow. ovf uses b' in its formula.
  - The sub bit travels with the beat, so mixed add/sub streams are legal.
- Not defined: no `sub` port; b'=b and c'=cin.

Test Plan (WIDTH=16, STAGES=4):
- Single add: a=0x1234, b=0x4321, cin=0 accepted at cycle T, out_ready=1 -> out_valid=1 at T+4, sum=0x5555, cout=0, ovf=0.
- Full carry ripple across all stages: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Streaming: 8 back-to-back beats a=i, b=0x0100*i for i=0..7, out_ready=1 -> 8 consecutive out_valid cycles starting 4 cycles after the first accept, in order, sum=0x0101*i; in_ready stays 1 throughout.
- Backpressure: stream 6 beats, drop out_ready for 5 cycles after the first result -> in_ready=0 during the stall; sum held stable; all 6 results delivered once, in order, after out_ready returns.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle at T+2 -> out_valid=0, sum=0 after reset; none of the 3 results ever appear; a new beat 0x0002+0x0003 yields 0x0005 four cycles after accept.
- With PIPELINED_ADDER_SUB_EN defined: sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0 (borrow). Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
